// File: rtl/motor_driver.sv
// motor_driver
//
// Turns a signed 8-bit velocity command into a PWM enable and a direction bit
// for an H-bridge. The command is sampled only at the end of each PWM period.
// Any reversal forces one full period of zero drive before the direction bit
// changes, so the bridge never changes direction while it is being driven.
//
// Ports:
//   cclk      in   1  system clock, all logic on its rising edge
//   rstb      in   1  synchronous active-low reset
//   velocity  in   8  signed command: sign = direction, magnitude = duty
//   ena       out  1  registered PWM enable
//   dir       out  1  registered direction, 0 = forward, 1 = reverse
//
// Parameters:
//   PRESCALE  system clocks per PWM count tick (>= 1)
//   PERIOD    PWM counts per period, also the full-scale magnitude (>= 1)
//
// Internal state of interest for checkers: pre, cnt, duty, pend, state.

module motor_driver #(
  parameter int PRESCALE = 8,
  parameter int PERIOD   = 127
) (
  input  logic       cclk,
  input  logic       rstb,
  input  logic [7:0] velocity,
  output logic       ena,
  output logic       dir
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  // cnt and duty share one width; duty must be able to hold PERIOD itself.
  localparam int CW = (PERIOD > 1) ? $clog2(PERIOD + 1) : 1;

  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(PERIOD - 1);
  localparam logic [CW-1:0] FULL     = CW'(PERIOD);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_BLANK = 1'b1;

  logic [PW-1:0] pre;
  logic [CW-1:0] cnt;
  logic [CW-1:0] duty;
  logic          pend;
  logic [0:0]    state;

  logic          tick;
  logic          boundary;
  logic          sgn;
  logic [8:0]    abs_v;
  logic [CW-1:0] mag;
  logic          ref_dir;
  logic          accept;

  assign tick     = (pre == PRE_LAST);
  assign boundary = tick && (cnt == CNT_LAST);
  assign sgn      = velocity[7];

  // Nine bits so that -128 becomes +128 before saturation.
  assign abs_v = sgn ? (9'd0 - {velocity[7], velocity}) : {1'b0, velocity};
  assign mag   = (int'(abs_v) > PERIOD) ? FULL : CW'(abs_v);

  // Leaving a blank, the command is judged against the direction being
  // committed (pend), not the one still showing on dir.
  assign ref_dir = (state == ST_BLANK) ? pend : dir;
  assign accept  = (mag == '0) || (sgn == ref_dir);

  always_ff @(posedge cclk) begin
    if (!rstb) begin
      pre   <= '0;
      cnt   <= '0;
      duty  <= '0;
      pend  <= 1'b0;
      state <= ST_RUN;
      ena   <= 1'b0;
      dir   <= 1'b0;
    end else begin
      pre <= tick ? '0 : pre + PW'(1);

      if (tick) begin
        cnt <= (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
      end

      // One clock behind the cnt/duty comparison; duty = 0 never enables,
      // duty = PERIOD always enables.
      ena <= (cnt < duty);

      if (boundary) begin
        if (state == ST_BLANK) begin
          dir <= pend;
        end
        if (accept) begin
          duty  <= mag;
          state <= ST_RUN;
        end else begin
          // Reversal: zero drive for the coming period, remember the target.
          duty  <= '0;
          pend  <= sgn;
          state <= ST_BLANK;
        end
      end
    end
  end

endmodule

// File: tb/tb_motor_driver.sv
// tb_motor_driver
//
// Drives one velocity command per PWM period (with random junk on velocity
// between boundaries) and measures each period's ena high-time and dir.
// Expected {high_clocks, dir} for the following period is pushed when the
// command is driven and popped when that period has been measured.

module tb_motor_driver;

  localparam int PRESCALE = 8;
  localparam int PERIOD   = 127;
  localparam int PCLK     = PRESCALE * PERIOD;  // 1016 clocks per period

  logic       cclk;
  logic       rstb;
  logic [7:0] velocity;
  logic       ena;
  logic       dir;

  // {high clocks in period [11:1], dir [0]}
  logic [11:0] exp_q[$];

  int checks = 0;
  int errors = 0;

  motor_driver #(
    .PRESCALE(PRESCALE),
    .PERIOD  (PERIOD)
  ) dut (
    .cclk    (cclk),
    .rstb    (rstb),
    .velocity(velocity),
    .ena     (ena),
    .dir     (dir)
  );

  // ---------------- clock / reset ----------------
  initial cclk = 1'b0;
  always #5 cclk = ~cclk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Runs one full PWM period. Velocity is random junk until just before the
  // closing boundary, where v is applied. Expected result for the next
  // period is pushed; the current period's expectation is popped and checked.
  task automatic do_period(input logic [7:0] v, input int next_high,
                           input logic next_dir, input bit push_next);
    int high;
    int dir_hits;
    logic [11:0] e;
    high     = 0;
    dir_hits = 0;
    if (push_next) exp_q.push_back({11'(next_high), next_dir});
    if (exp_q.size() == 0) begin
      check("queue_empty", 0, 1);
      return;
    end
    e = exp_q.pop_front();
    for (int i = 0; i < PCLK; i++) begin
      if (i < PCLK - 6) velocity = 8'($urandom_range(0, 255));
      else              velocity = v;
      @(posedge cclk);
      #1;
      if (ena === 1'b1) high++;
      // dir may legitimately change on the closing boundary edge (last sample).
      if (i < PCLK - 1 && dir === e[0]) dir_hits++;
    end
    check($sformatf("ena_high_v%02h", v), high, int'(e[11:1]));
    check($sformatf("dir_v%02h", v), dir_hits, PCLK - 1);
  endtask

  // Runs n clocks into a period, checks the pre-reset outputs, then resets.
  task automatic reset_mid(input int n, input logic exp_ena, input logic exp_dir);
    for (int i = 0; i < n; i++) begin
      velocity = 8'($urandom_range(0, 255));
      @(posedge cclk);
      #1;
    end
    check("pre_reset_ena", int'(ena), int'(exp_ena));
    check("pre_reset_dir", int'(dir), int'(exp_dir));
    rstb = 1'b0;
    @(posedge cclk);
    #1;
    check("mid_reset_ena", int'(ena), 0);
    check("mid_reset_dir", int'(dir), 0);
    rstb = 1'b1;
    exp_q.delete();
    exp_q.push_back({11'd0, 1'b0});  // first period after reset is always idle
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rstb     = 1'b0;
    velocity = 8'h00;
    repeat (3) @(posedge cclk);
    #1;
    check("reset_ena", int'(ena), 0);
    check("reset_dir", int'(dir), 0);
    rstb = 1'b1;
    exp_q.push_back({11'd0, 1'b0});

    do_period(8'h00, 0,    1'b0, 1'b1);
    do_period(8'h00, 0,    1'b0, 1'b1);
    do_period(8'h42, 528,  1'b0, 1'b1);  // 66 * 8
    do_period(8'h7F, PCLK, 1'b0, 1'b1);  // full scale
    do_period(8'hC6, 0,    1'b0, 1'b1);  // reversal -> blank, dir held
    do_period(8'hC6, 464,  1'b1, 1'b1);  // 58 * 8, now reverse
    do_period(8'h80, PCLK, 1'b1, 1'b1);  // -128 saturates, same sign, no blank
    do_period(8'h05, 0,    1'b1, 1'b1);  // reversal -> blank toward forward
    do_period(8'h81, 0,    1'b0, 1'b1);  // dir flips to 0, -127 differs -> blank again
    do_period(8'h00, 0,    1'b1, 1'b1);  // dir flips to 1, zero command loads duty 0
    do_period(8'h10, 0,    1'b1, 1'b1);  // reversal -> blank, dir still 1

    // Reset in the middle of the blank while reversing from dir = 1.
    reset_mid(400, 1'b0, 1'b1);

    do_period(8'h7F, PCLK, 1'b0, 1'b1);
    // Reset in the middle of a full-drive period.
    reset_mid(300, 1'b1, 1'b0);

    do_period(8'h10, 128,  1'b0, 1'b1);
    do_period(8'h01, 8,    1'b0, 1'b1);
    do_period(8'hFF, 0,    1'b0, 1'b1);  // -1: reversal -> blank
    do_period(8'hC0, 512,  1'b1, 1'b1);  // 64 * 8 reverse
    do_period(8'h00, 0,    1'b1, 1'b1);
    do_period(8'h00, 0,    1'b0, 1'b0);  // measure the last queued period

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #(PCLK * 30 * 10);
    errors++;
    $display("FAIL timeout: got no completion, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
